// File: rtl/fft_pkg.sv
// Shared constants and types for the 16-point radix-4 FFT datapath.
// Used by the input buffer, the butterfly and later stages.
package fft_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned TW_W     = 8;
    localparam int unsigned N_POINTS = 16;
    localparam int unsigned GROUPS   = 4;

    typedef enum logic [1:0] {
        BankEmpty,
        BankFilling,
        BankFull,
        BankDraining
    } bank_state_e;

    // Q1.7 twiddles, round-to-nearest, with 1.0 saturated to 127.
    localparam logic signed [TW_W-1:0] TW_Q17 [0:GROUPS-1] = '{
        8'sd127, 8'sd118, 8'sd91, 8'sd49
    };

endpackage

// File: rtl/fft_twiddle_rom.sv
// Combinational twiddle lookup: butterfly group index to Q1.7 twiddle.
module fft_twiddle_rom
    import fft_pkg::*;
(
    input  logic [1:0]             grp,
    output logic signed [TW_W-1:0] w
);

    always_comb begin
        w = TW_Q17[grp];
    end

endmodule

// File: rtl/fft_input_buffer.sv
// Ping-pong frame buffer for the 16-point FFT: fills one bank from a sample stream
// while the other drains as four stride-4 butterfly groups with their twiddles.
module fft_input_buffer
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_c,
    output logic [DATA_W-1:0] out_d,
    output logic [TW_W-1:0]   out_w,
    output logic [1:0]        out_group,
    output logic              out_last
);

    localparam logic [3:0] LastIdx = 4'(N_POINTS - 1);

    bank_state_e       bank_q [2];
    bank_state_e       bank_d [2];
    logic [DATA_W-1:0] mem_q  [2][N_POINTS];

    logic [3:0] wr_cnt_q, wr_cnt_d;
    logic       wr_sel_q, wr_sel_d;
    logic       rd_sel_q, rd_sel_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_a_q, out_b_q, out_c_q, out_d_q;
    logic [TW_W-1:0]   out_w_q;
    logic [1:0]        out_group_q;
    logic              out_last_q;

    logic                   accept;
    logic                   xfer;
    logic                   load;
    logic                   load_sel;
    logic [1:0]             load_grp;
    logic signed [TW_W-1:0] load_w;

    assign in_ready = rst_n &&
                      (bank_q[wr_sel_q] == BankEmpty || bank_q[wr_sel_q] == BankFilling);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;

    always_comb begin
        bank_d      = bank_q;
        wr_cnt_d    = wr_cnt_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;
        load_sel    = rd_sel_q;
        load_grp    = 2'd0;

        // 4-bit counter wraps to 0 on its own after the 16th sample.
        if (accept) begin
            wr_cnt_d         = wr_cnt_q + 4'd1;
            bank_d[wr_sel_q] = BankFilling;
            if (wr_cnt_q == LastIdx) begin
                bank_d[wr_sel_q] = BankFull;
                wr_sel_d         = !wr_sel_q;
            end
        end

        if (!out_valid_q) begin
            load = (bank_q[rd_sel_q] == BankFull);
        end else if (xfer) begin
            if (!out_last_q) begin
                load     = 1'b1;
                load_grp = out_group_q + 2'd1;
            end else begin
                bank_d[rd_sel_q] = BankEmpty;
                rd_sel_d         = !rd_sel_q;
                // Chain straight into the other frame only if it was already complete.
                if (bank_q[!rd_sel_q] == BankFull) begin
                    load     = 1'b1;
                    load_sel = !rd_sel_q;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
        end

        if (load) begin
            out_valid_d = 1'b1;
            if (load_grp == 2'd0) begin
                bank_d[load_sel] = BankDraining;
            end
        end
    end

    fft_twiddle_rom u_twiddle_rom (
        .grp (load_grp),
        .w   (load_w)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_q[0]   <= BankEmpty;
            bank_q[1]   <= BankEmpty;
            wr_cnt_q    <= 4'd0;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_c_q     <= '0;
            out_d_q     <= '0;
            out_w_q     <= '0;
            out_group_q <= 2'd0;
            out_last_q  <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            out_valid_q <= out_valid_d;
            if (load) begin
                out_a_q     <= mem_q[load_sel][{2'd0, load_grp}];
                out_b_q     <= mem_q[load_sel][{2'd1, load_grp}];
                out_c_q     <= mem_q[load_sel][{2'd2, load_grp}];
                out_d_q     <= mem_q[load_sel][{2'd3, load_grp}];
                out_w_q     <= load_w;
                out_group_q <= load_grp;
                out_last_q  <= (load_grp == 2'd3);
            end
        end
    end

    // Sample storage needs no reset; bank state alone says what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_sel_q][wr_cnt_q] <= in_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_c     = out_c_q;
    assign out_d     = out_d_q;
    assign out_w     = out_w_q;
    assign out_group = out_group_q;
    assign out_last  = out_last_q;

endmodule

// File: doc/fft_input_buffer.md
Name: fft_input_buffer

Overview:
- Upstream feeder for the radix-4 butterfly of the 16-point FFT.
- Collects a stream of 16 signed samples into one of two ping-pong banks, with valid/ready on the input side.
- Once a frame is complete, issues it as 4 butterfly groups {A,B,C,D} in stride-4 order, each with its Q1.7 twiddle, using valid/ready on the output side.
- While one bank drains, the other fills.

Parameters:
- DATA_W, 16, sample width (two's complement); matches butterfly A..D.
- TW_W, 8, twiddle width (Q1.7 signed); matches butterfly W.
- N_POINTS, 16, samples per frame; fixed, and not meant to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  DATA_W  sample; frame index is implied by arrival order 0..15.
- out_valid  out  1  group outputs are valid.
- out_ready  in  1  downstream accepts the group.
- out_a, out_b, out_c, out_d  out  DATA_W each  x[g], x[g+4], x[g+8], x[g+12].
- out_w  out  TW_W  twiddle for group g.
- out_group  out  2  group index g (0..3).
- out_last  out  1  high with g=3.

Behaviour:
- Reset and interfaces:
  - One clock domain.
  - Reset is synchronous and active-low.
  - While rst_n=0 at a clock edge: both banks marked EMPTY, write counter=0, wr_sel=0, rd_sel=0, group counter=0.
  - Outputs after reset: out_valid=0; out_a..out_d=0, out_w=0, out_group=0, out_last=0.
  - in_ready is forced to 0 while rst_n=0.
- Bank states: EMPTY, FILLING, FULL, DRAINING (one per bank, 2 bits each).
- Input accept:
  - A sample is accepted when in_valid and in_ready are both 1 at the edge.
  - in_ready = (bank[wr_sel] is EMPTY or FILLING). It is combinational from registered state only and never depends on out_ready.
  - Each accept writes bank[wr_sel][wr_cnt] and increments wr_cnt. The first accept moves the bank EMPTY->FILLING.
  - The accept at wr_cnt=15 moves the bank to FULL, wraps wr_cnt to 0 and toggles wr_sel, all in the same edge.
- Output issue:
  - When bank[rd_sel] is FULL and no group is held, the registered outputs load group 0 and out_valid=1 at the next edge. The bank goes to DRAINING.
  - Latency: the 16th sample is accepted at edge k; out_valid=1 after edge k+1.
- Output hold: while out_valid=1 and out_ready=0, all out_* hold stable.
- Group sequencing:
  - A transfer is out_valid and out_ready both 1.
  - A transfer of g<3 loads group g+1 at the same edge, so no bubble.
  - A transfer of g=3:
    - frees bank[rd_sel] (->EMPTY) and toggles rd_sel.
    - If the other bank was FULL before this edge, its group 0 loads in the same edge and out_valid stays 1; otherwise out_valid drops to 0.
- Twiddle table (constant, round-to-nearest, 1.0 saturated): g0=127, g1=118, g2=91, g3=49.
- Width: samples pass through bit-exact. No arithmetic on data; 0x8000 must pass unchanged.
- Simultaneous events:
  - Frame completion into one bank and release of the other bank in the same edge are independent; both take effect.
  - A bank freed at edge k makes in_ready=1 from cycle k+1, never combinationally in the same cycle.
- Full condition: both banks FULL/DRAINING means in_ready=0. in_valid is ignored and no data is lost.
- Reset mid-frame or mid-drain:
  - The partial frame and the undelivered groups are discarded.
  - Post-reset state is identical to power-on.
- Throughput: 16 input cycles per frame versus 4 output cycles. The input side is the limiter, so back-pressure only appears under out_ready stalls.

Decomposition:
- Package fft_pkg:
  - DATA_W, TW_W, N_POINTS, GROUPS=4.
  - The bank-state enum.
  - The twiddle constant array TW_Q17[0:3] = {127,118,91,49}.
  - This package is shared with the butterfly and later stages.
- Sub-module fft_twiddle_rom: combinational, group index -> out_w, read from fft_pkg constants. The rest (two 16xDATA_W register banks, counters, state) stays in fft_input_buffer.

Test Plan:
- Load ramp, out_ready=1:
  - Stimulus: feed x[i]=16*i continuously, out_ready=1.
  - g0: A=0,B=64,C=128,D=192,W=127.
  - g1: A=16,B=80,C=144,D=208,W=118.
  - g3: A=48,B=112,C=176,D=240,W=49, out_last=1.
  - out_valid rises the cycle after the 16th accept.
- Output stall:
  - Stimulus: out_ready=0 for 5 cycles during g1.
  - Required: out_* stable throughout; g2 follows exactly one edge after out_ready=1.
- Fill both banks with out_ready=0:
  - Stimulus: frames 0..15 then 100..115, out_ready=0.
  - Required: in_ready=0 after the 32nd accept.
  - Release out_ready: 8 back-to-back transfers with no out_valid gap; frame 2 starts at A=100 right after the frame-1 g3 transfer.
  - in_ready returns to 1 the cycle after the first frame's g3 transfer.
- Sign/extremes:
  - Stimulus: samples 0x8000, 0x7FFF, 0xFFFF.
  - Required: they appear bit-exact at the expected A..D positions.
- Reset mid-frame:
  - Stimulus: accept 9 samples, pulse rst_n=0 for 1 cycle, then send 16 new samples (e.g. all 5).
  - Required: groups contain only 5s, out_valid=0 during and after reset until the new frame completes.
- Input gaps:
  - Stimulus: in_valid toggles 1/0 randomly across 16 samples.
  - Required: group contents match arrival order, with no duplicated or skipped indices.
